ds18b20_bcd_conv: RTL and testbench

Converts the raw 16-bit two's-complement temperature word from `ds18b20_drive` into four display digits for `seg_drive`. It sits between the two blocks. The output format is sign/hundreds, tens, units and tenths, with the decimal point on digit 1. A new value is converted automatically whenever the input word changes. The conversion is a sequential magnitude/range-check/double-dabble engine with a one-cycle completion strobe.

---
 rtl/ds18b20_bcd_conv.sv | 151 +++++++++++++++
 tb/tb_ds18b20_bcd_conv.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ds18b20_bcd_conv.sv
// rtl/ds18b20_bcd_conv.sv - DS18B20 raw temperature word to four BCD display digits
// Optional feature macro: DS18B20_ROUND_EN (round tenths to nearest instead of truncating)
module ds18b20_bcd_conv (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] temperature,
    output logic [15:0] o_data,
    output logic        o_neg,
    output logic        o_err,
    output logic        o_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] t_last_q, t_last_d;
    logic        first_q, first_d;
    // {hundreds, tens, units, 8-bit binary integer part}
    logic [19:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        err_q, err_d;
    logic [3:0]  tenths_q, tenths_d;
    logic [15:0] o_data_q, o_data_d;
    logic        o_neg_q, o_neg_d;
    logic        o_err_q, o_err_d;
    logic        o_valid_q, o_valid_d;

    logic [15:0] mag;
    logic [11:0] int_part;
    logic [7:0]  frac_prod;
    logic [19:0] adj;

    // Double-dabble correction for one BCD nibble.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // Magnitude, integer/fraction split and the tenths product.
    always_comb begin
        mag      = t_last_q[15] ? (~t_last_q + 16'd1) : t_last_q;
        int_part = mag[15:4];
`ifdef DS18B20_ROUND_EN
        frac_prod = ({4'd0, mag[3:0]} * 8'd10) + 8'd8;
`else
        frac_prod = {4'd0, mag[3:0]} * 8'd10;
`endif
        adj = {add3(shift_q[19:16]), add3(shift_q[15:12]), add3(shift_q[11:8]), shift_q[7:0]};
    end

    // Next-state and datapath update for the conversion FSM.
    always_comb begin
        state_d   = state_q;
        t_last_d  = t_last_q;
        first_d   = first_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        err_d     = err_q;
        tenths_d  = tenths_q;
        o_data_d  = o_data_q;
        o_neg_d   = o_neg_q;
        o_err_d   = o_err_q;
        o_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (first_q || (temperature != t_last_q)) begin
                    t_last_d = temperature;
                    first_d  = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                neg_d = t_last_q[15];
                if (t_last_q[15] ? (int_part > 12'd99) : (int_part > 12'd199)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    err_d    = 1'b0;
                    shift_d  = {12'd0, int_part[7:0]};
                    tenths_d = frac_prod[7:4];
                    cnt_d    = 3'd0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = adj << 1;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_valid_d = 1'b1;
                o_neg_d   = neg_q;
                o_err_d   = err_q;
                if (err_q) begin
                    o_data_d = 16'hEEEE;
                end else begin
                    o_data_d = {(neg_q ? 4'hA : shift_q[19:16]), shift_q[15:12],
                                shift_q[11:8], tenths_q};
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            t_last_q  <= 16'h0000;
            first_q   <= 1'b1;
            shift_q   <= 20'd0;
            cnt_q     <= 3'd0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
            tenths_q  <= 4'd0;
            o_data_q  <= 16'h0000;
            o_neg_q   <= 1'b0;
            o_err_q   <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_last_q  <= t_last_d;
            first_q   <= first_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            err_q     <= err_d;
            tenths_q  <= tenths_d;
            o_data_q  <= o_data_d;
            o_neg_q   <= o_neg_d;
            o_err_q   <= o_err_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o_data  = o_data_q;
    assign o_neg   = o_neg_q;
    assign o_err   = o_err_q;
    assign o_valid = o_valid_q;

endmodule

// File: tb/tb_ds18b20_bcd_conv.sv
// tb/tb_ds18b20_bcd_conv.sv - self-checking bench for ds18b20_bcd_conv
module tb_ds18b20_bcd_conv;

    logic        clk;
    logic        rst;
    logic [15:0] temperature;
    logic [15:0] o_data;
    logic        o_neg;
    logic        o_err;
    logic        o_valid;

    int n_checks;
    int n_fails;

    ds18b20_bcd_conv dut (
        .clk         (clk),
        .rst         (rst),
        .temperature (temperature),
        .o_data      (o_data),
        .o_neg       (o_neg),
        .o_err       (o_err),
        .o_valid     (o_valid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [15:0] temp;
        logic [15:0] exp_data;
        logic        exp_neg;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Count edges (sampled on the following negedge) until o_valid is seen; -1 on timeout.
    task automatic wait_pulse(input int budget, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int p_edge[2];
        logic [15:0] p_data[2];

        n_checks = 0;
        n_fails  = 0;

        vecs[0]  = '{16'h0191, 16'h0250, 1'b0, 1'b0, 11};
        vecs[1]  = '{16'h0193, 16'h0251, 1'b0, 1'b0, 11};
        vecs[2]  = '{16'h019F, 16'h0259, 1'b0, 1'b0, 11};
        vecs[3]  = '{16'hFF5E, 16'hA101, 1'b1, 1'b0, 11};
        vecs[4]  = '{16'hFC90, 16'hA550, 1'b1, 1'b0, 11};
        vecs[5]  = '{16'h07D0, 16'h1250, 1'b0, 1'b0, 11};
        vecs[6]  = '{16'h0D00, 16'hEEEE, 1'b0, 1'b1, 3};
        vecs[7]  = '{16'h0C70, 16'h1990, 1'b0, 1'b0, 11};
        vecs[8]  = '{16'h0C80, 16'hEEEE, 1'b0, 1'b1, 3};
        vecs[9]  = '{16'hF9D0, 16'hA990, 1'b1, 1'b0, 11};
        vecs[10] = '{16'hF9C0, 16'hEEEE, 1'b1, 1'b1, 3};
        vecs[11] = '{16'hFFFF, 16'hA000, 1'b1, 1'b0, 11};
        vecs[12] = '{16'h8000, 16'hEEEE, 1'b1, 1'b1, 3};
        vecs[13] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 11};
        vecs[14] = '{16'h0198, 16'h0255, 1'b0, 1'b0, 11};
`ifdef DS18B20_ROUND_EN
        vecs[0].exp_data  = 16'h0251;
        vecs[1].exp_data  = 16'h0252;
        vecs[11].exp_data = 16'hA001;
`endif

        // Reset state, then first conversion after release.
        rst = 1'b1;
        temperature = 16'h0550;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(o_data), 32'h0000);
        check("reset_neg", 32'(o_neg), 32'h0);
        check("reset_err", 32'(o_err), 32'h0);
        check("reset_valid", 32'(o_valid), 32'h0);
        rst = 1'b0;
        wait_pulse(40, lat);
        check("first_lat", 32'(lat), 32'd11);
        check("first_data", 32'(o_data), 32'h0850);
        check("first_neg", 32'(o_neg), 32'h0);
        check("first_err", 32'(o_err), 32'h0);
        @(negedge clk);
        check("first_pulse_width", 32'(o_valid), 32'h0);
        check("first_hold", 32'(o_data), 32'h0850);

        // Table of conversions.
        for (int i = 0; i < 15; i++) begin
            temperature = vecs[i].temp;
            wait_pulse(40, lat);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_data", i), 32'(o_data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_neg", i), 32'(o_neg), 32'(vecs[i].exp_neg));
            check($sformatf("v%0d_err", i), 32'(o_err), 32'(vecs[i].exp_err));
            @(negedge clk);
            check($sformatf("v%0d_pulse_width", i), 32'(o_valid), 32'h0);
        end

        // Input change during a conversion is picked up afterwards.
        pulses = 0;
        p_edge[0] = -1; p_edge[1] = -1;
        p_data[0] = 16'h0; p_data[1] = 16'h0;
        temperature = 16'h0191;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 3) temperature = 16'h0200;
            if (o_valid) begin
                if (pulses < 2) begin
                    p_edge[pulses] = e;
                    p_data[pulses] = o_data;
                end
                pulses++;
            end
        end
        check("chg_pulses", 32'(pulses), 32'd2);
        check("chg_edge0", 32'(p_edge[0]), 32'd11);
`ifdef DS18B20_ROUND_EN
        check("chg_data0", 32'(p_data[0]), 32'h0251);
`else
        check("chg_data0", 32'(p_data[0]), 32'h0250);
`endif
        check("chg_edge1", 32'(p_edge[1]), 32'd22);
        check("chg_data1", 32'(p_data[1]), 32'h0320);

        // A change that reverts before IDLE causes no extra conversion.
        pulses = 0;
        temperature = 16'h0400;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 3) temperature = 16'h0777;
            if (e == 5) temperature = 16'h0400;
            if (o_valid) pulses++;
        end
        check("revert_pulses", 32'(pulses), 32'd1);
        check("revert_data", 32'(o_data), 32'h0640);

        // Reset in the middle of a conversion.
        temperature = 16'h0550;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(o_data), 32'h0000);
        check("midrst_valid", 32'(o_valid), 32'h0);
        temperature = 16'h0191;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_valid) pulses++;
        end
        check("midrst_no_pulse", 32'(pulses), 32'd0);
        rst = 1'b0;
        lat = -1;
        p_data[0] = 16'h0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_valid) begin
                if (pulses == 0) begin
                    lat = e;
                    p_data[0] = o_data;
                end
                pulses++;
            end
        end
        check("midrst_pulses", 32'(pulses), 32'd1);
        check("midrst_lat", 32'(lat), 32'd11);
`ifdef DS18B20_ROUND_EN
        check("midrst_data_after", 32'(p_data[0]), 32'h0251);
`else
        check("midrst_data_after", 32'(p_data[0]), 32'h0250);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
